// File: rtl/mccoy_prog_driver.sv
// mccoy_prog_driver: holds a short program for the McCoy core, resets the core,
// streams the program one instruction per clock and checks the core's results.
module mccoy_prog_driver #(
    parameter int          DEPTH      = 16,
    parameter int          RST_CYCLES = 2,
    parameter int          CHECK_LAT  = 1,
    parameter logic [5:0]  IDLE_INSTR = 6'b000000,
    localparam int         ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [5:0]        wr_instr,
    input  logic              wr_chk,
    input  logic [5:0]        wr_exp,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    output logic [5:0]        core_instr,
    output logic              core_rst,
    input  logic [7:0]        core_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_fail_addr
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {IDLE, CORE_RST, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic       chk;
        logic [5:0] exp_val;
        logic [5:0] instr;
    } entry_t;

    // One in-flight check: travels alongside the instruction until the core's result is due.
    typedef struct packed {
        logic              vld;
        logic [5:0]        exp_val;
        logic [ADDR_W-1:0] addr;
    } pend_t;

    entry_t            mem [DEPTH];
    pend_t             dl  [CHECK_LAT+1];

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W:0]   len, len_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [5:0]        core_instr_n;
    logic              core_rst_n, busy_n, done_n, pass_n;
    logic [7:0]        err_n;
    logic [ADDR_W-1:0] ffa_n;
    pend_t             push;

    entry_t            rd_entry;
    pend_t             retire;
    logic              mismatch;
    logic              last_issue;
    logic              unused_core_hi;

    assign rd_entry       = mem[pc];
    assign retire         = dl[CHECK_LAT];
    assign mismatch       = retire.vld && (core_out[5:0] != retire.exp_val);
    assign last_issue     = ({1'b0, pc} == (len - (ADDR_W+1)'(1)));
    assign unused_core_hi = ^core_out[7:6];

    // Program memory write port, locked out while a run is in progress.
    // NOTE: the program store has no reset; its contents are defined only by writes.
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            mem[wr_addr] <= '{chk: wr_chk, exp_val: wr_exp, instr: wr_instr};
    end

    // Next-state, next-output and result-accumulation logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_n      = state;
        pc_n         = pc;
        len_n        = len;
        cnt_n        = cnt;
        core_instr_n = IDLE_INSTR;
        core_rst_n   = 1'b0;
        busy_n       = busy;
        done_n       = done;
        pass_n       = pass;
        err_n        = err_count;
        ffa_n        = first_fail_addr;
        push         = '0;

        // Retire the oldest pending check against the core's current result.
        if (mismatch) begin
            if (err_count != 8'hFF)
                err_n = err_count + 8'd1;
            if (err_count == 8'd0)
                ffa_n = retire.addr;
        end

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    len_n  = (prog_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : prog_len;
                    err_n  = 8'd0;
                    ffa_n  = '0;
                    pass_n = 1'b0;
                    done_n = 1'b0;
                    pc_n   = '0;
                    cnt_n  = '0;
                    if (prog_len == '0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        pass_n  = 1'b1;
                    end else begin
                        state_n    = CORE_RST;
                        core_rst_n = 1'b1;
                        busy_n     = 1'b1;
                    end
                end
            end
            CORE_RST: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n      = cnt + CNT_W'(1);
                    core_rst_n = 1'b1;
                end
            end
            RUN: begin
                core_instr_n = rd_entry.instr;
                push         = '{vld: rd_entry.chk, exp_val: rd_entry.exp_val, addr: pc};
                if (last_issue) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    pc_n = pc + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == CNT_W'(CHECK_LAT)) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_n == 8'd0);
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, registered outputs and the check delay line.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state           <= IDLE;
            pc              <= '0;
            len             <= '0;
            cnt             <= '0;
            core_instr      <= IDLE_INSTR;
            core_rst        <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 8'd0;
            first_fail_addr <= '0;
            for (int i = 0; i <= CHECK_LAT; i++)
                dl[i] <= '0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            len             <= len_n;
            cnt             <= cnt_n;
            core_instr      <= core_instr_n;
            core_rst        <= core_rst_n;
            busy            <= busy_n;
            done            <= done_n;
            pass            <= pass_n;
            err_count       <= err_n;
            first_fail_addr <= ffa_n;
            dl[0]           <= push;
            for (int i = 1; i <= CHECK_LAT; i++)
                dl[i] <= dl[i-1];
        end
    end

endmodule

// File: tb/tb_mccoy_prog_driver.sv
// tb_mccoy_prog_driver: drives mccoy_prog_driver against a behavioural stand-in core
// and a program-level reference model of the expected run results.
module tb_mccoy_prog_driver;

    localparam int         DEPTH      = 16;
    localparam int         ADDR_W     = $clog2(DEPTH);
    localparam int         RST_CYCLES = 2;
    localparam int         CHECK_LAT  = 1;
    localparam logic [5:0] IDLE_INSTR = 6'b000000;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [5:0]        wr_instr;
    logic              wr_chk;
    logic [5:0]        wr_exp;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic [5:0]        core_instr;
    logic              core_rst;
    logic [7:0]        core_out = 8'd0;
    logic              busy, done, pass;
    logic [7:0]        err_count;
    logic [ADDR_W-1:0] first_fail_addr;

    // Reference copy of the program store.
    logic [5:0] m_instr [DEPTH];
    logic       m_chk   [DEPTH];
    logic [5:0] m_exp   [DEPTH];

    logic [5:0] issue_log [$];
    int         rst_cnt;
    int         n_cmp  = 0;
    int         n_fail = 0;

    mccoy_prog_driver #(
        .DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES), .CHECK_LAT(CHECK_LAT), .IDLE_INSTR(IDLE_INSTR)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_instr(wr_instr),
        .wr_chk(wr_chk), .wr_exp(wr_exp), .prog_len(prog_len), .start(start),
        .core_instr(core_instr), .core_rst(core_rst), .core_out(core_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_addr(first_fail_addr)
    );

    always #5 clk = ~clk;

    // Stand-in core result for an instruction (low 6 bits of io_out).
    function automatic logic [5:0] fcore(input logic [5:0] i);
        return 6'((int'(i) * 7) + 3);
    endfunction

    // Stand-in core: samples io_in at each edge, result visible one cycle later; top bits are noise.
    always @(posedge clk)
        core_out <= {2'($urandom), fcore(core_instr)};

    // Record what the core is fed while the driver is busy.
    always @(posedge clk) begin
        #1;
        if (busy && !core_rst) issue_log.push_back(core_instr);
        if (busy && core_rst)  rst_cnt++;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned expv);
        n_cmp++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic write_entry(input int a, input logic [5:0] ins, input logic c, input logic [5:0] e);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_instr = ins; wr_chk = c; wr_exp = e;
        @(negedge clk);
        wr_en = 1'b0;
        m_instr[a] = ins; m_chk[a] = c; m_exp[a] = e;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_core_rst"}, core_rst, 1);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_pass"}, pass, 0);
        check({pfx, "_err"}, err_count, 0);
        check({pfx, "_ffa"}, first_fail_addr, 0);
        check({pfx, "_instr"}, core_instr, IDLE_INSTR);
    endtask

    // mode 0: plain run; 1: write and start attempted mid-run; 2: reset mid-run.
    task automatic run_check(input string tag, input int len_in, input int mode);
        int  e_len, e_err, e_ffa, bad;
        bit  finished, disturbed;
        e_len = (len_in > DEPTH) ? DEPTH : len_in;
        e_err = 0; e_ffa = 0;
        for (int i = 0; i < e_len; i++)
            if (m_chk[i] && (m_exp[i] != fcore(m_instr[i]))) begin
                if (e_err == 0) e_ffa = i;
                if (e_err < 255) e_err++;
            end

        @(negedge clk);
        prog_len = (ADDR_W+1)'(len_in); start = 1'b1;
        issue_log.delete(); rst_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        finished = 0; disturbed = 0;
        for (int c = 0; c < 300 && !finished; c++) begin
            if (done && !busy) begin
                finished = 1;
            end else if (mode == 1 && !disturbed && issue_log.size() == 3) begin
                wr_en = 1'b1; wr_addr = ADDR_W'(5); wr_instr = ~m_instr[5]; wr_chk = 1'b1;
                wr_exp = 6'd0; start = 1'b1; prog_len = 1;
                disturbed = 1;
                @(negedge clk);
                wr_en = 1'b0; start = 1'b0;
            end else if (mode == 2 && issue_log.size() == 2) begin
                reset = 1'b1;
                @(negedge clk);
                check_reset_values({tag, "_midrst"});
                reset = 1'b0;
                @(negedge clk);
                check({tag, "_midrst_rel_core_rst"}, core_rst, 0);
                check({tag, "_midrst_rel_busy"}, busy, 0);
                return;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_done"}, done, 1);
        if (mode == 1) check({tag, "_disturb_applied"}, disturbed, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pass"}, pass, (e_err == 0) ? 1 : 0);
        check({tag, "_err"}, err_count, e_err);
        check({tag, "_ffa"}, first_fail_addr, e_ffa);
        check({tag, "_rst_cycles"}, rst_cnt, (e_len > 0) ? RST_CYCLES : 0);
        check({tag, "_issue_cycles"}, issue_log.size(), (e_len > 0) ? e_len + 1 + CHECK_LAT : 0);
        bad = 0;
        for (int i = 0; i < e_len; i++)
            if (issue_log.size() <= i + 1 || issue_log[i+1] !== m_instr[i]) bad++;
        check({tag, "_issue_seq_bad"}, bad, 0);
        repeat (2) @(negedge clk);
        check({tag, "_done_hold"}, done, 1);
        check({tag, "_err_hold"}, err_count, e_err);
        check({tag, "_idle_instr"}, core_instr, IDLE_INSTR);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_instr = '0; wr_chk = 1'b0;
        wr_exp = '0; prog_len = '0; start = 1'b0; rst_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_instr[i] = '0; m_chk[i] = 1'b0; m_exp[i] = '0;
        end

        // Reset state, with start asserted alongside reset (reset must win).
        start = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_core_rst", core_rst, 0);
        check("post_reset_busy", busy, 0);

        // Fill every entry so the whole store is defined.
        for (int i = 0; i < DEPTH; i++) write_entry(i, 6'(i * 5 + 1), 1'b0, 6'd0);

        // Short program, last entry checked with a matching result.
        write_entry(0, 6'b011000, 1'b0, 6'd0);
        write_entry(1, 6'b010101, 1'b0, 6'd0);
        write_entry(2, 6'b010000, 1'b0, 6'd0);
        write_entry(3, 6'b010001, 1'b1, fcore(6'b010001));
        run_check("add_ok", 4, 0);

        // Same program, last entry expects a wrong value.
        write_entry(3, 6'b010001, 1'b1, fcore(6'b010001) ^ 6'd1);
        run_check("add_bad", 4, 0);
        check("add_bad_ffa3", first_fail_addr, 3);
        check("add_bad_pass0", pass, 0);

        // Empty program, then an oversized length.
        run_check("len0", 0, 0);
        for (int i = 0; i < DEPTH; i++)
            write_entry(i, 6'($urandom), 1'($urandom), ($urandom_range(1) == 1) ? 6'($urandom) : 6'd0);
        for (int i = 0; i < DEPTH; i++)
            if (m_chk[i] && $urandom_range(1) == 1)
                write_entry(i, m_instr[i], 1'b1, fcore(m_instr[i]));
        run_check("len_over", DEPTH + 3, 0);

        // Writes and start while busy are ignored; reset mid-run aborts; rerun matches.
        run_check("disturb", 8, 1);
        run_check("abort", 8, 2);
        run_check("rerun", 8, 0);

        // Randomised programs and lengths.
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [5:0] ins;
                ins = 6'($urandom);
                write_entry(i, ins, 1'($urandom),
                            ($urandom_range(2) != 0) ? fcore(ins) : 6'($urandom));
            end
            run_check($sformatf("rand%0d", r), $urandom_range(DEPTH + 4), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
